// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO narrow beats (lane 0 first) into one
// registered wide word, closing early on in_last_i with a contiguous lane strobe.
module stream_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATA_WIDTH-1:0]       in_data_i,
    input  logic                        in_last_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [RATIO*DATA_WIDTH-1:0] out_data_o,
    output logic [RATIO-1:0]            out_strb_o,
    output logic                        out_last_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    localparam int unsigned LW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    if (RATIO < 2) begin : g_ratio_check
        $error("stream_packer: RATIO must be >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_width_check
        $error("stream_packer: DATA_WIDTH must be >= 1");
    end

    logic [LW-1:0]               lane_q, lane_d;
    logic [RATIO*DATA_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [RATIO-1:0]            asm_strb_q, asm_strb_d;
    logic [RATIO*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]            out_strb_q, out_strb_d;
    logic                        out_last_q, out_last_d;
    logic                        out_valid_q, out_valid_d;

    logic [RATIO*DATA_WIDTH-1:0] beat_data;
    logic [RATIO-1:0]            beat_strb;
    logic                        accept;
    logic                        complete;

    assign in_ready_o  = !out_valid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign complete    = accept && ((lane_q == LAST_LANE) || in_last_i);

    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;

    // Assembly contents with the current beat merged in; used both for the
    // partial update and for the word loaded on completion.
    always_comb begin
        beat_data = asm_data_q;
        beat_strb = asm_strb_q;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (LW'(k) == lane_q) begin
                beat_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                beat_strb[k]                          = 1'b1;
            end
        end
    end

    always_comb begin
        lane_d      = lane_q;
        asm_data_d  = asm_data_q;
        asm_strb_d  = asm_strb_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (complete) begin
            out_data_d  = beat_data;
            out_strb_d  = beat_strb;
            out_last_d  = in_last_i;
            out_valid_d = 1'b1;
            lane_d      = '0;
            asm_data_d  = '0;
            asm_strb_d  = '0;
        end else begin
            if (accept) begin
                asm_data_d = beat_data;
                asm_strb_d = beat_strb;
                lane_d     = lane_q + LW'(1);
            end
            if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lane_q      <= '0;
            asm_data_q  <= '0;
            asm_strb_q  <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            asm_data_q  <= asm_data_d;
            asm_strb_q  <= asm_strb_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (DW=8, RATIO=4): packet-level scoreboard
// checked every cycle, plus directed literal expectations.
module tb_stream_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned R  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [R*DW-1:0] out_data;
    logic [R-1:0]  out_strb;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_strb_o (out_strb),
        .out_last_o (out_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    // Model: beats of the packet in progress, and words completed but not yet consumed.
    logic [DW-1:0]   part[$];
    logic [R*DW-1:0] wq_data[$];
    logic [R-1:0]    wq_strb[$];
    logic            wq_last[$];

    logic            prev_stall = 1'b0;
    logic [R*DW-1:0] prev_data;
    logic [R-1:0]    prev_strb;
    logic            prev_last;
    int unsigned     beats_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic lst);
        logic [R*DW-1:0] d;
        logic [R-1:0]    s;
        d = '0;
        s = '0;
        for (int i = 0; i < part.size(); i++) begin
            d[i*DW +: DW] = part[i];
            s[i]          = 1'b1;
        end
        wq_data.push_back(d);
        wq_strb.push_back(s);
        wq_last.push_back(lst);
        part.delete();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic r, input logic rs = 1'b1);
        logic acc, hs;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        rst_n     = rs;
        #1;
        chk("out_valid", out_valid, wq_data.size() > 0);
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && wq_data.size() > 0) begin
            chk("out_data", out_data, wq_data[0]);
            chk("out_strb", out_strb, wq_strb[0]);
            chk("out_last", out_last, wq_last[0]);
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", {out_last, out_strb, out_data}, {prev_last, prev_strb, prev_data});
        end
        prev_stall = out_valid && !out_ready && rs;
        prev_data  = out_data;
        prev_strb  = out_strb;
        prev_last  = out_last;
        hs  = out_valid && out_ready;
        acc = v && in_ready;
        if (!rs) begin
            part.delete();
            wq_data.delete();
            wq_strb.delete();
            wq_last.delete();
            prev_stall = 1'b0;
        end else begin
            if (hs) begin
                void'(wq_data.pop_front());
                void'(wq_strb.pop_front());
                void'(wq_last.pop_front());
            end
            if (acc) begin
                beats_acc++;
                part.push_back(d);
                if (l || part.size() == R) push_word(l);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string name, input logic [R*DW-1:0] d,
                            input logic [R-1:0] s, input logic lst);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_strb"}, out_strb, s);
        chk({name, "_last"}, out_last, lst);
    endtask

    logic [R*DW-1:0] bb_words [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};

    initial begin
        int unsigned guard;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_strb", out_strb, 4'h0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_ready", in_ready, 1'b1);

        cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 0, 1);
        cycle(1, 8'h33, 0, 1); cycle(1, 8'h44, 1, 1);
        chk_word("full", 32'h44332211, 4'hF, 1'b1);

        cycle(1, 8'hA1, 0, 1); cycle(1, 8'hA2, 1, 1);
        chk_word("short", 32'h0000A2A1, 4'h3, 1'b1);
        cycle(0, 8'h00, 0, 1);

        for (int i = 1; i <= 12; i++) begin
            cycle(1, 8'(i), i == 12, 1);
            if (i % 4 == 0) chk_word("b2b", bb_words[i/4-1], 4'hF, i == 12);
        end
        cycle(0, 8'h00, 0, 1);

        cycle(1, 8'hB1, 1, 0);
        chk_word("lane0_last", 32'h000000B1, 4'h1, 1'b1);
        repeat (5) cycle(1, 8'hC5, 0, 0);
        chk("stall_ready", in_ready, 1'b0);
        chk("stall_held", out_data, 32'h000000B1);
        cycle(0, 8'h00, 0, 1);
        chk("release_valid", out_valid, 1'b0);

        cycle(1, 8'h55, 0, 1); cycle(1, 8'h66, 0, 1);
        cycle(0, 8'h00, 0, 1, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, 32'h0);
        chk("midrst_strb", out_strb, 4'h0);
        cycle(1, 8'h77, 0, 1); cycle(1, 8'h88, 0, 1);
        cycle(1, 8'h99, 0, 1); cycle(1, 8'hAA, 1, 1);
        chk_word("post_rst", 32'hAA998877, 4'hF, 1'b1);

        beats_acc = 0;
        guard = 0;
        while (beats_acc < 1000 && guard < 20000) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0);
            guard++;
        end
        chk("rand_beats", beats_acc, 1000);
        repeat (3) cycle(0, 8'h00, 0, 1);
        chk("drained", wq_data.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
